// File: rtl/ritc_vcdl_scan_pkg.sv
// ---------------------------------------------------------------------------
// ritc_vcdl_scan_pkg
// Shared definitions for the RITC VCDL phase scanner:
//   TAP_W / NTAPS  - IDELAY tap address width and tap count
//   scan_state_e   - scanner FSM state encoding
//   cnt_w_calc()   - width of a counter that must hold 0..sample_cycles
// ---------------------------------------------------------------------------
package ritc_vcdl_scan_pkg;

    localparam int TAP_W = 5;
    localparam int NTAPS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_EVAL    = 3'd4,
        ST_RESTORE = 3'd5,
        ST_DONE    = 3'd6
    } scan_state_e;

    // A full window of ones must fit without saturating.
    function automatic int cnt_w_calc(input int sample_cycles);
        return $clog2(sample_cycles + 1);
    endfunction

endpackage

// File: rtl/ritc_vcdl_scan_hist_ram.sv
// ---------------------------------------------------------------------------
// ritc_vcdl_scan_hist_ram
// Simple dual-port RAM holding one sample count per IDELAY tap.
// One synchronous write port, one read port with a registered output
// (data appears one cycle after the address), so it maps onto block RAM.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - registered read data
// ---------------------------------------------------------------------------
module ritc_vcdl_scan_hist_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array or read register: keeps the block RAM inference
    // intact; contents are only meaningful after a scan has written them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ritc_vcdl_phase_scanner.sv
// ---------------------------------------------------------------------------
// ritc_vcdl_phase_scanner
// Sweeps all 32 IDELAY taps on the VCDL sync copy, counts high samples of
// the returned signal per tap, reports the first tap whose count departs
// from the tap-0 baseline by more than THRESH, and finally reloads the
// IDELAY with that tap (or tap 0 when no edge was seen).
//
// Optional feature macro: RITC_VCDL_SCAN_HIST_EN
//   defined   - per-tap counts stored in a 32-entry RAM, read via hist_*
//   undefined - no RAM; hist_data_o tied to 0, hist_addr_i unused
//
// Ports:
//   CLK              - system clock (shared with the VCDL generator)
//   rst_n_i          - synchronous active-low reset
//   idelayctrl_rdy_i - IDELAYCTRL ready; dropping it aborts a scan
//   start_i          - single-cycle scan request (IDLE and ready only)
//   vcdl_sync_i      - delayed VCDL sync from the IDELAY
//   delay_o          - tap value to the IDELAY
//   load_delay_o     - one-cycle IDELAY load strobe
//   busy_o           - scan in progress
//   done_o           - one-cycle completion pulse
//   err_o            - sticky abort flag, cleared by the next accepted start
//   edge_found_o     - edge detected in the last scan
//   edge_tap_o       - detected edge tap (0 when none)
//   ref_count_o      - tap-0 sample count
//   hist_addr_i      - histogram read address
//   hist_data_o      - histogram read data (one cycle latency)
// ---------------------------------------------------------------------------
module ritc_vcdl_phase_scanner
    import ritc_vcdl_scan_pkg::*;
#(
    parameter  int SETTLE_CYCLES = 8,
    parameter  int SAMPLE_CYCLES = 256,
    parameter  int THRESH        = 16,
    localparam int CNT_W         = cnt_w_calc(SAMPLE_CYCLES)
) (
    input  logic             CLK,
    input  logic             rst_n_i,
    input  logic             idelayctrl_rdy_i,
    input  logic             start_i,
    input  logic             vcdl_sync_i,
    output logic [TAP_W-1:0] delay_o,
    output logic             load_delay_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             edge_found_o,
    output logic [TAP_W-1:0] edge_tap_o,
    output logic [CNT_W-1:0] ref_count_o,
    input  logic [TAP_W-1:0] hist_addr_i,
    output logic [CNT_W-1:0] hist_data_o
);

    // Phase counter shared by SETTLE and SAMPLE; sized for the longer one.
    localparam int PH_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  SAMPLE_LAST = PH_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NTAPS - 1);

    scan_state_e      state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic             edge_found_q, edge_found_d;
    logic [TAP_W-1:0] edge_tap_q, edge_tap_d;
    logic [TAP_W-1:0] delay_q, delay_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic             busy_q;
    logic             done_q;
    logic             sync_q;

    // Signed difference one bit wider than the counts, then its magnitude.
    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] diff_mag;
    logic                  over_thresh;

    assign diff        = $signed({1'b0, cnt_q}) - $signed({1'b0, ref_q});
    assign diff_mag    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign over_thresh = (int'(diff_mag) > THRESH);

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        ph_d         = ph_q;
        cnt_d        = cnt_q;
        ref_d        = ref_q;
        edge_found_d = edge_found_q;
        edge_tap_d   = edge_tap_q;
        delay_d      = delay_q;
        load_d       = 1'b0;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && idelayctrl_rdy_i) begin
                    state_d      = ST_LOAD;
                    tap_d        = '0;
                    err_d        = 1'b0;
                    edge_found_d = 1'b0;
                    edge_tap_d   = '0;
                    // Strobe and tap are registered so they are presented
                    // during the LOAD cycle itself.
                    delay_d      = '0;
                    load_d       = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
                ph_d    = '0;
            end
            ST_SETTLE: begin
                if (ph_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    ph_d    = '0;
                    cnt_d   = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                cnt_d = cnt_q + CNT_W'(sync_q);
                if (ph_q == SAMPLE_LAST) begin
                    state_d = ST_EVAL;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_EVAL: begin
                if (tap_q == '0) begin
                    ref_d = cnt_q;
                end else if (!edge_found_q && over_thresh) begin
                    edge_found_d = 1'b1;
                    edge_tap_d   = tap_q;
                end
                load_d = 1'b1;
                if (tap_q == LAST_TAP) begin
                    // Uses the _d values so an edge found at the last tap
                    // is the one restored.
                    state_d = ST_RESTORE;
                    delay_d = edge_found_d ? edge_tap_d : '0;
                end else begin
                    state_d = ST_LOAD;
                    tap_d   = tap_q + 1'b1;
                    delay_d = tap_q + 1'b1;
                end
            end
            ST_RESTORE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing IDELAYCTRL ready invalidates everything measured so far.
        if (state_q != ST_IDLE && !idelayctrl_rdy_i) begin
            state_d      = ST_IDLE;
            err_d        = 1'b1;
            load_d       = 1'b0;
            delay_d      = delay_q;
            edge_found_d = 1'b0;
            edge_tap_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            ph_q         <= '0;
            cnt_q        <= '0;
            ref_q        <= '0;
            edge_found_q <= 1'b0;
            edge_tap_q   <= '0;
            delay_q      <= '0;
            load_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sync_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            edge_found_q <= edge_found_d;
            edge_tap_q   <= edge_tap_d;
            delay_q      <= delay_d;
            load_q       <= load_d;
            err_q        <= err_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            sync_q       <= vcdl_sync_i;
        end
    end

    assign delay_o      = delay_q;
    assign load_delay_o = load_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign edge_found_o = edge_found_q;
    assign edge_tap_o   = edge_tap_q;
    assign ref_count_o  = ref_q;

`ifdef RITC_VCDL_SCAN_HIST_EN
    ritc_vcdl_scan_hist_ram #(
        .ADDR_W (TAP_W),
        .DATA_W (CNT_W)
    ) u_hist_ram (
        .clk_i   (CLK),
        .we_i    (state_q == ST_EVAL),
        .waddr_i (tap_q),
        .wdata_i (cnt_q),
        .raddr_i (hist_addr_i),
        .rdata_o (hist_data_o)
    );
`else
    logic unused_hist_addr;
    assign unused_hist_addr = ^hist_addr_i;
    assign hist_data_o      = '0;
`endif

endmodule

// File: tb/tb_ritc_vcdl_phase_scanner.sv
// ---------------------------------------------------------------------------
// tb_ritc_vcdl_phase_scanner
// Drives the phase scanner against a behavioural IDELAY model whose per-tap
// high-sample count is chosen by the bench, and compares the scanner's
// results with expectations computed directly from the per-tap counts.
// ---------------------------------------------------------------------------
module tb_ritc_vcdl_phase_scanner;

    localparam int S     = 8;
    localparam int N     = 256;
    localparam int TH    = 16;
    localparam int CW    = $clog2(N + 1);
    localparam int TPT   = 2 + S + N;
    localparam int EXP_CYC = 32 * TPT + 2;
    localparam int LIMIT = EXP_CYC + 200;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          rdy_i = 1'b1;
    logic          start_i = 1'b0;
    logic          vcdl_sync_i = 1'b0;
    logic [4:0]    delay_o;
    logic          load_delay_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          edge_found_o;
    logic [4:0]    edge_tap_o;
    logic [CW-1:0] ref_count_o;
    logic [4:0]    hist_addr_i = '0;
    logic [CW-1:0] hist_data_o;

    int n_checks = 0;
    int n_errors = 0;

    // Desired number of high samples the IDELAY model returns per tap.
    int k [32];
    int strobes [$];

    always #5 clk = ~clk;

    ritc_vcdl_phase_scanner #(
        .SETTLE_CYCLES (S),
        .SAMPLE_CYCLES (N),
        .THRESH        (TH)
    ) dut (
        .CLK              (clk),
        .rst_n_i          (rst_n_i),
        .idelayctrl_rdy_i (rdy_i),
        .start_i          (start_i),
        .vcdl_sync_i      (vcdl_sync_i),
        .delay_o          (delay_o),
        .load_delay_o     (load_delay_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .edge_found_o     (edge_found_o),
        .edge_tap_o       (edge_tap_o),
        .ref_count_o      (ref_count_o),
        .hist_addr_i      (hist_addr_i),
        .hist_data_o      (hist_data_o)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // IDELAY model: latches the tap on each load strobe, then returns either
    // a constant 1 (count == N) or a burst of k ones placed well inside the
    // sample window, zeros elsewhere.
    initial begin
        int cur_tap;
        int off;
        cur_tap = 0;
        off = 0;
        forever begin
            @(negedge clk);
            if (load_delay_o) begin
                cur_tap = int'(delay_o);
                off = 0;
            end else begin
                off++;
            end
            if (k[cur_tap] >= N)
                vcdl_sync_i = 1'b1;
            else
                vcdl_sync_i = (off >= S + 4) && (off < S + 4 + k[cur_tap]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expected_result(output int ef, output int et, output int rf);
        rf = k[0];
        ef = 0;
        et = 0;
        for (int t = 1; t < 32; t++) begin
            int d;
            d = k[t] - k[0];
            if (d < 0) d = -d;
            if (ef == 0 && d > TH) begin
                ef = 1;
                et = t;
            end
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_scan(input string name, input bit inject_busy_start);
        int ef, et, rf, n, restore_exp;
        int got [33];
        expected_result(ef, et, rf);
        restore_exp = ef ? et : 0;
        strobes.delete();
        pulse_start();
        n = 1;
        if (load_delay_o) strobes.push_back(int'(delay_o));
        while (!done_o && n < LIMIT) begin
            if (inject_busy_start && n == 500) start_i = 1'b1;
            tick();
            start_i = 1'b0;
            n++;
            if (load_delay_o) strobes.push_back(int'(delay_o));
        end
        check_eq({name, " done_cycles"}, n, EXP_CYC);
        check_eq({name, " edge_found"}, edge_found_o, ef);
        check_eq({name, " edge_tap"}, edge_tap_o, et);
        check_eq({name, " ref_count"}, ref_count_o, rf);
        check_eq({name, " err"}, err_o, 0);
        check_eq({name, " strobe_count"}, strobes.size(), 33);
        for (int i = 0; i < 33; i++) got[i] = (i < strobes.size()) ? strobes[i] : 99;
        for (int i = 0; i < 32; i++) check_eq({name, " strobe_tap"}, got[i], i);
        check_eq({name, " restore_tap"}, got[32], restore_exp);
        tick();
        check_eq({name, " done_pulse_width"}, done_o, 0);
        check_eq({name, " busy_after"}, busy_o, 0);
`ifdef RITC_VCDL_SCAN_HIST_EN
        for (int t = 0; t < 32; t++) begin
            hist_addr_i = 5'(t);
            tick();
            check_eq({name, " hist"}, hist_data_o, k[t]);
        end
`else
        hist_addr_i = 5'd13;
        tick();
        check_eq({name, " hist_tied"}, hist_data_o, 0);
`endif
        $display("scan %s: %0d cycles, edge_found=%0d edge_tap=%0d ref=%0d", name, n,
                 edge_found_o, edge_tap_o, ref_count_o);
    endtask

    task automatic random_pattern();
        int base, e;
        base = int'($urandom_range(40, 200));
        e = int'($urandom_range(1, 40));
        k[0] = base;
        for (int t = 1; t < 32; t++) begin
            if (t < e)
                k[t] = base + int'($urandom_range(0, 32)) - 16;
            else if (t == e)
                k[t] = ($urandom_range(0, 1) != 0) ? base + int'($urandom_range(17, 39))
                                                   : base - int'($urandom_range(17, 39));
            else
                k[t] = int'($urandom_range(0, N - 8));
        end
    endtask

    task automatic edge_pattern(input int e);
        for (int t = 0; t < 32; t++) k[t] = (t < e) ? N : 0;
    endtask

    // Runs the current scan until the given cycle count after acceptance.
    task automatic advance_to(input int target, output int n);
        n = 1;
        while (n < target && !done_o) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, dones;
        for (int t = 0; t < 32; t++) k[t] = 0;

        // Reset state.
        repeat (3) tick();
        check_eq("rst delay", delay_o, 0);
        check_eq("rst load", load_delay_o, 0);
        check_eq("rst busy", busy_o, 0);
        check_eq("rst done", done_o, 0);
        check_eq("rst err", err_o, 0);
        check_eq("rst edge_found", edge_found_o, 0);
        check_eq("rst ref", ref_count_o, 0);
        rst_n_i = 1'b1;
        tick();

        // Start with IDELAYCTRL not ready is ignored.
        rdy_i = 1'b0;
        pulse_start();
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            dones += int'(load_delay_o) + int'(busy_o);
            tick();
        end
        check_eq("rdy0 start ignored", dones, 0);
        rdy_i = 1'b1;
        tick();

        // No edge, with a stray start while busy.
        for (int t = 0; t < 32; t++) k[t] = 0;
        run_scan("no_edge", 1'b1);

        edge_pattern(13);
        run_scan("edge13", 1'b0);

        for (int t = 0; t < 32; t++) k[t] = N;
        k[5] = N - 16;
        run_scan("drop16", 1'b0);
        k[5] = N - 17;
        run_scan("drop17", 1'b0);

        for (int r = 0; r < 2; r++) begin
            random_pattern();
            run_scan("random", 1'b0);
        end

        // Abort: rdy drops during tap 7 SAMPLE, after an edge at tap 3.
        edge_pattern(3);
        pulse_start();
        advance_to(7 * TPT + S + 50, n);
        check_eq("abort pre edge_found", edge_found_o, 1);
        rdy_i = 1'b0;
        tick();
        check_eq("abort busy", busy_o, 0);
        check_eq("abort err", err_o, 1);
        check_eq("abort load", load_delay_o, 0);
        check_eq("abort edge_found", edge_found_o, 0);
        check_eq("abort delay_hold", delay_o, 7);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            dones += int'(done_o);
            tick();
        end
        check_eq("abort no_done", dones, 0);
        check_eq("abort err sticky", err_o, 1);
        rdy_i = 1'b1;
        tick();
        $display("abort: err=%0d busy=%0d delay=%0d", err_o, busy_o, delay_o);

        // New start clears err; then reset during tap 20.
        edge_pattern(13);
        pulse_start();
        check_eq("restart err", err_o, 0);
        check_eq("restart busy", busy_o, 1);
        check_eq("restart load", load_delay_o, 1);
        check_eq("restart delay", delay_o, 0);
        advance_to(20 * TPT + 50, n);
        check_eq("pre_rst edge_found", edge_found_o, 1);
        rst_n_i = 1'b0;
        tick();
        check_eq("midrst delay", delay_o, 0);
        check_eq("midrst load", load_delay_o, 0);
        check_eq("midrst busy", busy_o, 0);
        check_eq("midrst done", done_o, 0);
        check_eq("midrst err", err_o, 0);
        check_eq("midrst edge_found", edge_found_o, 0);
        check_eq("midrst edge_tap", edge_tap_o, 0);
        check_eq("midrst ref", ref_count_o, 0);
        rst_n_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            dones += int'(load_delay_o) + int'(busy_o) + int'(done_o);
        end
        check_eq("post_rst quiet", dones, 0);
        $display("reset mid-scan: busy=%0d load=%0d", busy_o, load_delay_o);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ritc_vcdl_phase_scanner.md
# ritc_vcdl_phase_scanner

Automated phase scanner for the RITC VCDL loopback path. Sweeps all 32 IDELAY taps on the VCDL sync copy and counts high samples of the returned delayed signal at each tap. Reports the first tap where the count departs from the tap-0 baseline, then leaves the IDELAY loaded at that tap. Sits directly downstream of the VCDL generator: it consumes its delayed sync output and drives its delay-value and load-strobe inputs.

## Interface
Parameters:
- SETTLE_CYCLES, 8: wait cycles after each delay load before sampling; minimum 2.
- SAMPLE_CYCLES, 256: samples counted per tap.
- THRESH, 16: edge declared when |count(tap) − count(0)| > THRESH.

Ports:
- CLK  in  1  system clock; the same clock the VCDL generator uses.
- rst_n_i  in  1  synchronous, active-low reset.
- idelayctrl_rdy_i  in  1  IDELAYCTRL ready indication.
- start_i  in  1  single-cycle scan request.
- vcdl_sync_i  in  1  delayed VCDL sync returned from the IDELAY.
- delay_o  out  5  tap value presented to the IDELAY.
- load_delay_o  out  1  one-cycle IDELAY load strobe.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan completion.
- err_o  out  1  sticky abort flag; cleared by the next accepted start.
- edge_found_o  out  1  an edge was detected in the last scan.
- edge_tap_o  out  5  detected edge tap; 0 if no edge was found.
- ref_count_o  out  CNT_W  tap-0 count; CNT_W = $clog2(SAMPLE_CYCLES+1).
- hist_addr_i  in  5  histogram read address.
- hist_data_o  out  CNT_W  histogram read data.

## Operation
- Input conditioning: vcdl_sync_i passes through one register before it is counted. That stage is covered by the settle time.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, EVAL, RESTORE, DONE.
- IDLE → LOAD: requires start_i=1 and idelayctrl_rdy_i=1. On entry, tap=0, err_o cleared, edge_found_o cleared, edge_tap_o cleared.
  - start_i with rdy=0 is ignored.
  - start_i outside IDLE is ignored.
- LOAD (1 cycle): delay_o=tap and load_delay_o=1 in the same cycle, both registered. Next state SETTLE.
- SETTLE: lasts SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: lasts SAMPLE_CYCLES cycles. Count increments on each registered sample equal to 1. Saturation cannot occur, by construction of CNT_W.
- EVAL (1 cycle):
  - Tap 0: count is stored to ref_count_o.
  - Tap > 0 with no edge found yet and |count − ref| > THRESH: edge_found_o=1, edge_tap_o=tap. Only the first qualifying tap is recorded.
  - Difference is computed at CNT_W+1 bits, signed.
  - tap==31 → RESTORE. Otherwise tap+1 → LOAD. The tap counter never wraps.
- RESTORE (1 cycle): load_delay_o=1, delay_o = edge_found_o ? edge_tap_o : 0. Next state DONE.
- DONE (1 cycle): done_o=1. Next state IDLE.
- busy_o is 1 in every state except IDLE.
- idelayctrl_rdy_i falling in any non-IDLE state aborts the scan:
  - next state IDLE; err_o=1; no done_o pulse; load_delay_o=0.
  - delay_o holds its last value.
  - edge results are invalid, and edge_found_o is forced to 0.
- Reset values: all outputs 0; FSM in IDLE; tap=0; count=0. Reset has priority over every event, including mid-scan. No load strobe is emitted during or after reset.

## Timing
- Cycles per tap: 2 + SETTLE_CYCLES + SAMPLE_CYCLES.
- Full scan: 32·(2+SETTLE_CYCLES+SAMPLE_CYCLES) + 2 cycles from the accepting edge to done_o. With defaults: 8514 cycles.
- done_o, edge_*, and ref_count_o are stable in the done_o cycle and held until the next accepted start.
- Histogram reads: hist_data_o is valid 1 cycle after hist_addr_i (registered read). Contents are defined only when busy_o=0.

## Configuration
- RITC_VCDL_SCAN_HIST_EN
  - Defined: per-tap counts are written at EVAL into a 32×CNT_W RAM, readable via hist_addr_i/hist_data_o.
  - Undefined: no RAM is built; hist_data_o is tied 0 and hist_addr_i is unused. Edge detection is unchanged.

## Structure
- Package ritc_vcdl_scan_pkg holds:
  - TAP_W=5 and NTAPS=32;
  - the FSM state enum;
  - a CNT_W helper function.
- Sub-module ritc_vcdl_scan_hist_ram: simple dual-port, 1 write/1 read, registered read. Instantiated only under RITC_VCDL_SCAN_HIST_EN.

## Test plan
- No edge: vcdl_sync_i held 0, start pulse → 32 load strobes with delay_o 0..31; done_o after 8514 cycles; edge_found_o=0, edge_tap_o=0; final RESTORE loads tap 0.
- Edge at tap 13: model returns all-1 samples for taps 0–12 and all-0 for taps ≥13 → ref_count_o=256, edge_found_o=1, edge_tap_o=13; RESTORE strobe with delay_o=13.
- Sub-threshold change: count drops by exactly 16 at tap 5 → no edge. Count drops by 17 at tap 5 → edge_tap_o=5.
- start_i while busy, and start_i with rdy=0 → ignored; no extra load strobe; cycle count unchanged.
- rdy deasserted during tap 7 SAMPLE → next cycle IDLE, err_o=1, busy_o=0, no done_o. A new start clears err_o.
- rst_n_i low during tap 20 → all outputs 0 next cycle. With HIST_EN defined, after a clean scan of the tap-13 model: read addr 12 → 256, addr 13 → 0.
